// File: rtl/spi_deserializer.sv
// spi_deserializer: serial-to-parallel receiver for the SPI datapath.
// Samples `in` on every rising clk edge while `en` is high and assembles
// WIDTH-bit words, delivering each with a one-cycle `valid` strobe.
// Dropping `en` mid-frame discards the partial word and pulses `abort`.
//
// Parameters:
//   WIDTH     data bits per word (2..32)
//   LSB_FIRST 1: first serial bit lands in out[0]; 0: in out[WIDTH-1]
//   CNT_W     width of the completed-frame counter (wraps)
//
// Ports:
//   clk        bit clock, rising edge
//   rst        synchronous active-high reset
//   en         frame active (chip-select, active high)
//   in         serial data
//   out        last completed word, held until the next completion
//   valid      one-cycle pulse when out updates
//   busy       high while a frame is partially received
//   abort      one-cycle pulse when en drops mid-frame
//   parity_err even-parity failure flag for the word on out
//   frame_cnt  completed words since reset
//
// Optional feature macro: SPI_DESER_PARITY_EN
//   Defined: each frame carries one extra even-parity bit after the data bits.
//   Undefined: no parity bit, parity_err is constant 0.
module spi_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             busy,
  output logic             abort,
  output logic             parity_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [BCW-1:0]   bit_cnt, bit_cnt_d;
  logic [WIDTH-1:0] sr, sr_d, sr_shift, out_d;
  logic [CNT_W-1:0] frame_cnt_d;
  logic             valid_d, busy_d, abort_d, parity_err_d;

  // Shift register with the current serial bit inserted
  always_comb begin
    if (LSB_FIRST != 0) sr_shift = {in, sr[WIDTH-1:1]};
    else                sr_shift = {sr[WIDTH-2:0], in};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    sr_d         = sr;
    out_d        = out;
    valid_d      = 1'b0;
    abort_d      = 1'b0;
    parity_err_d = parity_err;
    frame_cnt_d  = frame_cnt;

    case (state)
      IDLE, SHIFT: begin
        if (en) begin
          sr_d      = sr_shift;
          bit_cnt_d = bit_cnt + BCW'(1);
          state_d   = SHIFT;
          if (bit_cnt == BCW'(WIDTH - 1)) begin
`ifdef SPI_DESER_PARITY_EN
            // All data bits in; the next enabled edge carries parity
            state_d   = PAR;
            bit_cnt_d = BCW'(WIDTH);
`else
            out_d       = sr_shift;
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt + CNT_W'(1);
            sr_d        = '0;
            bit_cnt_d   = '0;
            state_d     = IDLE;
`endif
          end
        end else if (state == SHIFT) begin
          abort_d   = 1'b1;
          sr_d      = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      PAR: begin
        if (en) begin
          // Word is delivered even when the parity check fails
          out_d        = sr;
          valid_d      = 1'b1;
          parity_err_d = (^sr) ^ in;
          frame_cnt_d  = frame_cnt + CNT_W'(1);
          sr_d         = '0;
          bit_cnt_d    = '0;
          state_d      = IDLE;
        end else begin
          abort_d   = 1'b1;
          sr_d      = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        sr_d      = '0;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      out        <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      abort      <= 1'b0;
      parity_err <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      sr         <= sr_d;
      out        <= out_d;
      valid      <= valid_d;
      busy       <= busy_d;
      abort      <= abort_d;
      parity_err <= parity_err_d;
      frame_cnt  <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_spi_deserializer.sv
// tb_spi_deserializer: directed self-checking bench for spi_deserializer.
// Three instances share clk/rst:
//   a: WIDTH=8,  LSB_FIRST=1, CNT_W=16
//   b: WIDTH=12, LSB_FIRST=0, CNT_W=16
//   c: WIDTH=8,  LSB_FIRST=0, CNT_W=2
// Honours SPI_DESER_PARITY_EN the same way the design does.
module tb_spi_deserializer;

`ifdef SPI_DESER_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  logic clk, rst;
  logic en_a, in_a, en_b, in_b, en_c, in_c;
  logic [7:0]  out_a;
  logic [11:0] out_b;
  logic [7:0]  out_c;
  logic valid_a, busy_a, abort_a, perr_a;
  logic valid_b, busy_b, abort_b, perr_b;
  logic valid_c, busy_c, abort_c, perr_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int n_checks = 0;
  int n_errors = 0;

  spi_deserializer #(.WIDTH(8), .LSB_FIRST(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .in(in_a), .out(out_a), .valid(valid_a),
    .busy(busy_a), .abort(abort_a), .parity_err(perr_a), .frame_cnt(cnt_a));

  spi_deserializer #(.WIDTH(12), .LSB_FIRST(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .in(in_b), .out(out_b), .valid(valid_b),
    .busy(busy_b), .abort(abort_b), .parity_err(perr_b), .frame_cnt(cnt_b));

  spi_deserializer #(.WIDTH(8), .LSB_FIRST(0), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en_c), .in(in_c), .out(out_c), .valid(valid_c),
    .busy(busy_c), .abort(abort_c), .parity_err(perr_c), .frame_cnt(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_out(input int sel);
    case (sel)
      0:       return 32'(out_a);
      1:       return 32'(out_b);
      default: return 32'(out_c);
    endcase
  endfunction

  function automatic logic [31:0] get_cnt(input int sel);
    case (sel)
      0:       return 32'(cnt_a);
      1:       return 32'(cnt_b);
      default: return 32'(cnt_c);
    endcase
  endfunction

  function automatic logic [3:0] get_flags(input int sel); // {valid,busy,abort,perr}
    case (sel)
      0:       return {valid_a, busy_a, abort_a, perr_a};
      1:       return {valid_b, busy_b, abort_b, perr_b};
      default: return {valid_c, busy_c, abort_c, perr_c};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on the selected instance (others held idle)
  task automatic drive(input int sel, input logic e, input logic b);
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    case (sel)
      0:       begin en_a = e; in_a = b; end
      1:       begin en_b = e; in_b = b; end
      default: begin en_c = e; in_c = b; end
    endcase
    tick();
  endtask

  // Send one full frame with en high; checks strobe/busy every cycle, word and parity at the end
  task automatic send_word(input int sel, input int w, input bit lsb,
                           input logic [31:0] word, input logic pbit, input string tag);
    int n;
    logic b;
    logic [3:0] f;
    logic exp_perr;
    n = w + PAR_EN;
    for (int i = 0; i < n; i++) begin
      if (i < w) b = lsb ? word[i] : word[w-1-i];
      else       b = pbit;
      drive(sel, 1'b1, b);
      f = get_flags(sel);
      check({tag, ".valid"}, 32'(f[3]), 32'(i == n-1));
      check({tag, ".busy"},  32'(f[2]), 32'(i != n-1));
    end
    exp_perr = (PAR_EN != 0) ? ((^word) ^ pbit) : 1'b0;
    f = get_flags(sel);
    check({tag, ".out"},  get_out(sel), word);
    check({tag, ".perr"}, 32'(f[0]), 32'(exp_perr));
  endtask

  initial begin
    logic [3:0] f;
    rst = 1'b1;
    en_a = 0; in_a = 0; en_b = 0; in_b = 0; en_c = 0; in_c = 0;
    tick(); tick();

    // Reset state
    for (int s = 0; s < 3; s++) begin
      check("rst.out", get_out(s), 32'h0);
      check("rst.cnt", get_cnt(s), 32'h0);
      check("rst.flags", 32'(get_flags(s)), 32'h0);
    end
    rst = 1'b0;

    // Test 1: A5 LSB first
    send_word(0, 8, 1'b1, 32'hA5, 1'b0, "t1");
    check("t1.cnt", get_cnt(0), 32'd1);
    drive(0, 1'b0, 1'b0);
    f = get_flags(0);
    check("t1.valid_drop", 32'(f[3]), 32'd0);
    check("t1.no_abort", 32'(f[1]), 32'd0);
    check("t1.hold", get_out(0), 32'hA5);

    // Test 2: WIDTH=12 MSB first, then back-to-back 8-bit words
    send_word(1, 12, 1'b0, 32'hABC, 1'b0, "t2.abc");
    check("t2.cnt_b", get_cnt(1), 32'd1);
    send_word(2, 8, 1'b0, 32'h3C, 1'b0, "t2.w0");
    send_word(2, 8, 1'b0, 32'hC3, 1'b0, "t2.w1");
    check("t2.cnt_c", get_cnt(2), 32'd2);
    drive(2, 1'b0, 1'b0);

    // Test 3: abort after 5 bits of the next word
    send_word(0, 8, 1'b1, 32'hA5, 1'b0, "t3.a5");
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 1'b1);
      f = get_flags(0);
      check("t3.busy_part", 32'(f[2]), 32'd1);
    end
    drive(0, 1'b0, 1'b0);
    f = get_flags(0);
    check("t3.abort", 32'(f[1]), 32'd1);
    check("t3.busy", 32'(f[2]), 32'd0);
    check("t3.valid", 32'(f[3]), 32'd0);
    check("t3.out", get_out(0), 32'hA5);
    check("t3.cnt", get_cnt(0), 32'd2);
    drive(0, 1'b0, 1'b0);
    f = get_flags(0);
    check("t3.abort_pulse", 32'(f[1]), 32'd0);
    send_word(0, 8, 1'b1, 32'h5A, 1'b0, "t3.5a");
    check("t3.cnt2", get_cnt(0), 32'd3);
    drive(0, 1'b0, 1'b0);

    // Test 4: reset after 3 bits, with en still high (rst wins)
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b1);
    rst = 1'b1;
    en_a = 1'b1; in_a = 1'b1;
    tick();
    rst = 1'b0;
    check("t4.out", get_out(0), 32'h0);
    check("t4.cnt", get_cnt(0), 32'h0);
    check("t4.flags", 32'(get_flags(0)), 32'h0);
    check("t4.cnt_c", get_cnt(2), 32'h0);
    drive(0, 1'b0, 1'b0);
    f = get_flags(0);
    check("t4.no_abort", 32'(f[1]), 32'd0);
    send_word(0, 8, 1'b1, 32'h96, 1'b0, "t4.96");
    check("t4.cnt1", get_cnt(0), 32'd1);
    drive(0, 1'b0, 1'b0);

    // Test 5: CNT_W=2 wrap over 5 back-to-back words
    for (int k = 0; k < 5; k++) begin
      send_word(2, 8, 1'b0, 32'(8'h11 * (k + 1)), 1'b0, "t5");
      check("t5.cnt", get_cnt(2), 32'((k + 1) % 4));
    end
    drive(2, 1'b0, 1'b0);

    // Test 6: parity (expected parity_err is 0 when the feature is off)
    send_word(0, 8, 1'b1, 32'hA5, 1'b0, "t6.p0");
    drive(0, 1'b0, 1'b0);
    send_word(0, 8, 1'b1, 32'hA5, 1'b1, "t6.p1");
    drive(0, 1'b0, 1'b0);
    send_word(0, 8, 1'b1, 32'h07, 1'b1, "t6.p2");
    check("t6.cnt", get_cnt(0), 32'd4);
    drive(0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_deserializer.md
Name: spi_deserializer

Overview:
Parametrised serial-to-parallel receiver for the SPI datapath. It is the successor to the fixed 8-bit shifter and adds the following:
- configurable word width and bit order;
- a frame-enable qualifier, with abort on early deassertion;
- a one-cycle valid strobe and a frame counter.

It sits behind the SPI pad logic and feeds received words to downstream register and FIFO logic in the same clock domain.

Parameters:
WIDTH, 8, data bits per word (2..32)
LSB_FIRST, 1, 1 = first serial bit lands in out[0]; 0 = first serial bit lands in out[WIDTH-1]
CNT_W, 16, width of the completed-frame counter

Ports:
clk  input  1  bit clock; all sampling on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  frame active (chip-select, active high); bit sampled only when en=1
in  input  1  serial data
out  output  WIDTH  last completed word; held until next completion
valid  output  1  one-cycle pulse when out updates
busy  output  1  1 while a frame is partially received
abort  output  1  one-cycle pulse when en drops mid-frame
parity_err  output  1  parity result for word on out (see Optional Feature)
frame_cnt  output  CNT_W  number of completed words since reset; wraps at 2^CNT_W

Behaviour:
- Reset (rst=1 at a rising edge) clears all state: out=0, valid=0, busy=0, abort=0, parity_err=0, frame_cnt=0, internal shift register=0, bit counter=0, state=IDLE.
- rst has priority over every other input.
- States:
  - IDLE: bit counter = 0.
  - SHIFT: 0 < bit counter < WIDTH.
  - PAR: only with the Optional Feature; waiting for the parity bit.
- IDLE, en=1: sample in as bit 0; bit counter = 1; go to SHIFT. If WIDTH bits are now complete, treat as completion instead.
- SHIFT, en=1: sample the next bit; increment the bit counter.
- Bit placement:
  - LSB_FIRST=1: shift right, new bit enters at MSB, so after WIDTH bits the first bit is at [0].
  - LSB_FIRST=0: shift left, new bit enters at LSB.
- Completion is the edge at which the WIDTH-th data bit is sampled (without the feature). At that edge, all registered:
  - out <= assembled word; valid <= 1; frame_cnt <= frame_cnt+1 (modulo 2^CNT_W);
  - bit counter <= 0; state <= IDLE.
- Latency: out and valid are visible in the cycle after the last bit's sampling edge.
- Back-to-back frames: with en held high continuously, a new word completes every WIDTH cycles with no gap cycle. valid pulses once per word and never stays high for two consecutive cycles, except when WIDTH would allow it.
- SHIFT (or PAR), en=0:
  - abort <= 1 for one cycle; discard the partial word (shift register and bit counter cleared); state <= IDLE.
  - out, valid, frame_cnt and parity_err are unchanged.
- IDLE, en=0: no action. abort stays 0.
- busy = (state != IDLE), registered.
- Reset mid-frame discards the partial word. No abort pulse is generated.

Optional Feature:
Macro SPI_DESER_PARITY_EN.
- Defined:
  - After the WIDTH-th data bit the block enters PAR instead of completing.
  - The next en=1 edge samples the parity bit. Completion occurs at that edge.
  - parity_err <= (XOR of data bits) XOR parity bit, i.e. 1 on even-parity failure. It updates together with valid and holds until the next completion.
  - Each frame is WIDTH+1 cycles.
  - The word is delivered even when parity fails.
  - en=0 in PAR aborts as above.
- Not defined: no PAR state; parity_err is tied to 0; frames are WIDTH cycles.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, en=1, in=1,0,1,0,0,1,0,1 over 8 edges -> out=8'hA5, valid=1 for exactly one cycle after the 8th edge, frame_cnt=1, busy=0 after completion.
2. WIDTH=12, LSB_FIRST=0, serial 0xABC MSB first -> out=12'hABC after the 12th edge; then 0x3C and 0xC3 back-to-back at WIDTH=8 with en never low -> two valid pulses 8 cycles apart, out=8'h3C then 8'hC3, frame_cnt=2.
3. Abort: 8'hA5 received, then 5 bits of a new word, then en=0 -> abort pulse one cycle, out stays 8'hA5, frame_cnt unchanged; next full word 8'h5A completes correctly.
4. Reset mid-frame: rst=1 after 3 bits -> all outputs 0 next cycle, no abort pulse; following full word received correctly from bit 0.
5. CNT_W=2: send 5 words -> frame_cnt sequence 1,2,3,0,1.
6. SPI_DESER_PARITY_EN defined, WIDTH=8:
   - 8'hA5 + parity 0 -> valid after the 9th edge, parity_err=0.
   - 8'hA5 + parity 1 -> parity_err=1, out=8'hA5.
